// File: rtl/tia_audio_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tia_audio_pkg
// Purpose  : Shared constants and LFSR step helpers for the TIA audio generator.
// Revision : 1.0
// ============================================================================
package tia_audio_pkg;

    localparam logic [1:0] REG_AUDC = 2'd0;
    localparam logic [1:0] REG_AUDF = 2'd1;
    localparam logic [1:0] REG_AUDV = 2'd2;
    localparam logic [1:0] REG_RSVD = 2'd3;

    localparam logic [3:0] AUDC_HIGH0       = 4'd0;
    localparam logic [3:0] AUDC_POLY4       = 4'd1;
    localparam logic [3:0] AUDC_DIV31_POLY4 = 4'd2;
    localparam logic [3:0] AUDC_POLY5_POLY4 = 4'd3;
    localparam logic [3:0] AUDC_PURE0       = 4'd4;
    localparam logic [3:0] AUDC_PURE1       = 4'd5;
    localparam logic [3:0] AUDC_DIV31A      = 4'd6;
    localparam logic [3:0] AUDC_POLY5A      = 4'd7;
    localparam logic [3:0] AUDC_POLY9       = 4'd8;
    localparam logic [3:0] AUDC_POLY5B      = 4'd9;
    localparam logic [3:0] AUDC_DIV31B      = 4'd10;
    localparam logic [3:0] AUDC_HIGH1       = 4'd11;
    localparam logic [3:0] AUDC_DIV3A       = 4'd12;
    localparam logic [3:0] AUDC_DIV3B       = 4'd13;
    localparam logic [3:0] AUDC_DIV3_DIV31  = 4'd14;
    localparam logic [3:0] AUDC_DIV3_POLY5  = 4'd15;

    localparam logic [3:0] POLY4_SEED = 4'hF;
    localparam logic [4:0] POLY5_SEED = 5'h1F;
    localparam logic [8:0] POLY9_SEED = 9'h1FF;

    localparam int POLY4_TAP_A = 3;
    localparam int POLY4_TAP_B = 2;
    localparam int POLY5_TAP_A = 4;
    localparam int POLY5_TAP_B = 2;
    localparam int POLY9_TAP_A = 8;
    localparam int POLY9_TAP_B = 4;

    localparam logic [4:0] DIV31_HIGH = 5'd18;
    localparam logic [4:0] DIV31_LAST = 5'd30;
    localparam logic [1:0] DIV3_LAST  = 2'd2;

    // Shift left, feedback into bit 0
    function automatic logic [3:0] poly4_step(input logic [3:0] p);
        return {p[2:0], p[POLY4_TAP_A] ^ p[POLY4_TAP_B]};
    endfunction

    function automatic logic [4:0] poly5_step(input logic [4:0] p);
        return {p[3:0], p[POLY5_TAP_A] ^ p[POLY5_TAP_B]};
    endfunction

    function automatic logic [8:0] poly9_step(input logic [8:0] p);
        return {p[7:0], p[POLY9_TAP_A] ^ p[POLY9_TAP_B]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/tia_audio_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : tia_audio_gen_if
// Purpose  : TIA register-bus write port (strobe, write enable, address, data).
// Revision : 1.0
// ============================================================================
interface tia_audio_gen_if #(
    parameter int ADDR_WIDTH = 5
);
    logic                  stb;
    logic                  we;
    logic [ADDR_WIDTH-1:0] adr;
    logic [7:0]            dat;

    modport master (output stb, output we, output adr, output dat);
    modport slave  (input  stb, input  we, input  adr, input  dat);
endinterface
`default_nettype wire

// File: rtl/tia_audio_gen_chan.sv
`default_nettype none
// ============================================================================
// Module   : tia_audio_chan
// Purpose  : One audio channel: AUDC/AUDF/AUDV, waveform state, sigma-delta.
// Revision : 1.0
// ============================================================================
module tia_audio_chan
    import tia_audio_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_tick,
    input  wire logic       i_wr_audc,
    input  wire logic       i_wr_audf,
    input  wire logic       i_wr_audv,
    input  wire logic [4:0] i_dat,
    output logic            o_pdm,
    output logic [3:0]      o_level
);

    logic [3:0] r_audc, r_audv, r_p4, r_acc;
    logic [4:0] r_audf, r_fcnt, r_p5, r_d31;
    logic [8:0] r_p9;
    logic [1:0] r_d3;
    logic       r_bit, r_pdm;

    logic [3:0] w_p4_n;
    logic [4:0] w_p5_n, w_d31_n, w_d31_step;
    logic [8:0] w_p9_n;
    logic [1:0] w_d3_n, w_d3_step;
    logic       w_bit_n, w_d3_wrap, w_pulse, w_bit_eff;
    logic [4:0] w_sd;

    assign w_pulse = i_tick && (r_fcnt == r_audf);

    always_comb begin
        w_p4_n     = r_p4;
        w_p5_n     = r_p5;
        w_p9_n     = r_p9;
        w_d31_n    = r_d31;
        w_d3_n     = r_d3;
        w_bit_n    = r_bit;
        w_d31_step = (r_d31 == DIV31_LAST) ? 5'd0 : r_d31 + 5'd1;
        w_d3_wrap  = (r_d3 == DIV3_LAST);
        w_d3_step  = w_d3_wrap ? 2'd0 : r_d3 + 2'd1;
        if (w_pulse) begin
            case (r_audc)
                AUDC_POLY4: begin
                    w_p4_n  = poly4_step(r_p4);
                    w_bit_n = w_p4_n[3];
                end
                AUDC_DIV31_POLY4: begin
                    w_d31_n = w_d31_step;
                    if (r_d31 == DIV31_LAST) w_p4_n = poly4_step(r_p4);
                    w_bit_n = w_p4_n[3];
                end
                AUDC_POLY5_POLY4: begin
                    w_p5_n = poly5_step(r_p5);
                    if (w_p5_n[4]) w_p4_n = poly4_step(r_p4);
                    w_bit_n = w_p4_n[3];
                end
                AUDC_PURE0, AUDC_PURE1: w_bit_n = ~r_bit;
                AUDC_DIV31A, AUDC_DIV31B: begin
                    w_d31_n = w_d31_step;
                    w_bit_n = (w_d31_n < DIV31_HIGH);
                end
                AUDC_POLY5A, AUDC_POLY5B: begin
                    w_p5_n  = poly5_step(r_p5);
                    w_bit_n = w_p5_n[4];
                end
                AUDC_POLY9: begin
                    w_p9_n  = poly9_step(r_p9);
                    w_bit_n = w_p9_n[8];
                end
                AUDC_DIV3A, AUDC_DIV3B: begin
                    w_d3_n = w_d3_step;
                    if (w_d3_wrap) w_bit_n = ~r_bit;
                end
                AUDC_DIV3_DIV31: begin
                    w_d3_n = w_d3_step;
                    if (w_d3_wrap) begin
                        w_d31_n = w_d31_step;
                        w_bit_n = (w_d31_n < DIV31_HIGH);
                    end
                end
                AUDC_DIV3_POLY5: begin
                    w_d3_n = w_d3_step;
                    if (w_d3_wrap) begin
                        w_p5_n  = poly5_step(r_p5);
                        w_bit_n = w_p5_n[4];
                    end
                end
                default: ;
            endcase
        end
    end

    // Modes 0 and 11 hold the output high regardless of pulses
    assign w_bit_eff = (r_audc == AUDC_HIGH0) || (r_audc == AUDC_HIGH1) || r_bit;
    assign o_level   = w_bit_eff ? r_audv : 4'd0;
    assign w_sd      = {1'b0, r_acc} + {1'b0, o_level};
    assign o_pdm     = r_pdm;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_audc <= '0;
            r_audf <= '0;
            r_audv <= '0;
            r_fcnt <= '0;
            r_p4   <= POLY4_SEED;
            r_p5   <= POLY5_SEED;
            r_p9   <= POLY9_SEED;
            r_d31  <= '0;
            r_d3   <= '0;
            r_bit  <= 1'b0;
            r_acc  <= '0;
            r_pdm  <= 1'b0;
        end else begin
            if (i_wr_audc) r_audc <= i_dat[3:0];
            if (i_wr_audf) r_audf <= i_dat;
            if (i_wr_audv) r_audv <= i_dat[3:0];
            if (i_tick)    r_fcnt <= w_pulse ? 5'd0 : r_fcnt + 5'd1;
            r_p4  <= w_p4_n;
            r_p5  <= w_p5_n;
            r_p9  <= w_p9_n;
            r_d31 <= w_d31_n;
            r_d3  <= w_d3_n;
            r_bit <= w_bit_n;
            r_acc <= w_sd[3:0];
            r_pdm <= w_sd[4];
        end
    end

endmodule
`default_nettype wire

// File: rtl/tia_audio_gen.sv
`default_nettype none
// ============================================================================
// Module   : tia_audio_gen
// Purpose  : N-channel TIA-style audio generator: prescaler, bus decode, mixer.
// Revision : 1.0
// ============================================================================
module tia_audio_gen
    import tia_audio_pkg::*;
#(
    parameter  int NUM_CH     = 2,
    parameter  int ADDR_WIDTH = 5,
    parameter  int TICK_DIV   = 38,
    localparam int MIX_W      = 4 + $clog2(NUM_CH + 1)
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    tia_audio_gen_if.slave     bus,
    output logic [NUM_CH-1:0]  pdm_o,
    output logic [MIX_W-1:0]   mix_o,
    output logic               tick_o
);

    localparam int CH_W  = ADDR_WIDTH - 2;
    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] c_pre_last = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] r_pre;
    logic             w_tick;
    logic [CH_W-1:0]  w_ch;
    logic [1:0]       w_reg;
    logic             w_wr;
    logic             w_unused_dat;
    logic [3:0]       w_level [NUM_CH];
    logic [MIX_W-1:0] w_sum;

    assign w_tick = (r_pre == c_pre_last);
    assign tick_o = w_tick;

    always_ff @(posedge clk_i) begin
        if (rst_i || w_tick) r_pre <= '0;
        else                 r_pre <= r_pre + PRE_W'(1);
    end

    // Channels at or beyond NUM_CH simply match no generate instance
    assign w_ch         = bus.adr[ADDR_WIDTH-1:2];
    assign w_reg        = bus.adr[1:0];
    assign w_wr         = bus.stb && bus.we && (w_reg != REG_RSVD);
    assign w_unused_dat = ^bus.dat[7:5];

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
            logic w_sel;
            assign w_sel = w_wr && (w_ch == CH_W'(g));
            tia_audio_chan u_chan (
                .clk       (clk_i),
                .rst       (rst_i),
                .i_tick    (w_tick),
                .i_wr_audc (w_sel && (w_reg == REG_AUDC)),
                .i_wr_audf (w_sel && (w_reg == REG_AUDF)),
                .i_wr_audv (w_sel && (w_reg == REG_AUDV)),
                .i_dat     (bus.dat[4:0]),
                .o_pdm     (pdm_o[g]),
                .o_level   (w_level[g])
            );
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < NUM_CH; i++) w_sum = w_sum + MIX_W'(w_level[i]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) mix_o <= '0;
        else       mix_o <= w_sum;
    end

endmodule
`default_nettype wire
